sap_core: RTL and testbench

- Parametrised successor to the fixed 8-bit SAP-1 datapath: a single-accumulator CPU core with generic data/address width.
- Adds an extended instruction set (immediate load, store, jumps, conditional jumps on flags), a loadable program RAM, and RUN/STEP execution modes.
- Sits under the chip top-level wrapper in place of the SAP-1 top; the external host loads programs through a write port.

---
 rtl/sap_pkg.sv | 28 ++
 rtl/sap_alu.sv | 26 ++
 rtl/sap_core.sv | 173 +++++++++++++++++
 tb/tb_sap_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared opcode/state encodings for the sap_core accumulator CPU.
// Field widths used to slice instruction words live here too.
package sap_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/sap_alu.sv
// sap_alu: combinational add/subtract with carry and zero flags.
// On subtract, CARRY is the inverted borrow (1 when A >= B).
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              SUB,
    output logic [DATA_W-1:0] RESULT,
    output logic              CARRY,
    output logic              ZERO
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    // two's complement subtract as A + ~B + 1
    always_comb begin
        b_eff  = SUB ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, SUB};
        RESULT = sum[DATA_W-1:0];
        CARRY  = sum[DATA_W];
        ZERO   = (sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/sap_core.sv
// sap_core: single-accumulator CPU, 2-cycle FETCH/EXEC per instruction,
// host-loadable program RAM, RUN/STEP execution modes.
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              STEP,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [DATA_W-1:0] A_OUT,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    output logic              CARRY,
    output logic              ZERO,
    output logic              HALTED
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IR_W  = ADDR_W + OPC_W;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] out_q;
    logic              out_v;
    logic              c_flag;
    logic              z_flag;

    opcode_t           opc;
    logic [ADDR_W-1:0] opd;
    logic [DATA_W-1:0] m_rd;
    logic [DATA_W-1:0] fetch_word;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    logic              do_fetch;
    logic              ld_a;
    logic              arith;
    logic              jump;
    logic              sta_we;
    logic              out_en;
    logic              prog_ok;
    logic [DATA_W-1:0] a_nxt;

    assign opc        = opcode_t'(ir[IR_W-1:ADDR_W]);
    assign opd        = ir[ADDR_W-1:0];
    assign m_rd       = mem[opd];
    assign fetch_word = mem[pc];

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .A      (acc),
        .B      (m_rd),
        .SUB    (opc == OP_SUB),
        .RESULT (alu_res),
        .CARRY  (alu_c),
        .ZERO   (alu_z)
    );

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic; HALT is only left through reset
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (RUN || STEP) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (opc == OP_HLT) state_nxt = S_HALT;
                else if (RUN)      state_nxt = S_FETCH;
                else               state_nxt = S_IDLE;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // control decode from state and current instruction
    always_comb begin
        do_fetch = 1'b0;
        ld_a     = 1'b0;
        arith    = 1'b0;
        jump     = 1'b0;
        sta_we   = 1'b0;
        out_en   = 1'b0;
        prog_ok  = 1'b0;
        a_nxt    = acc;
        case (state)
            S_IDLE, S_HALT: prog_ok = 1'b1;
            S_FETCH:        do_fetch = 1'b1;
            S_EXEC: begin
                case (opc)
                    OP_LDA: begin
                        ld_a  = 1'b1;
                        a_nxt = m_rd;
                    end
                    OP_ADD, OP_SUB: begin
                        ld_a  = 1'b1;
                        arith = 1'b1;
                        a_nxt = alu_res;
                    end
                    OP_STA: sta_we = 1'b1;
                    OP_LDI: begin
                        ld_a  = 1'b1;
                        a_nxt = {{(DATA_W-ADDR_W){1'b0}}, opd};
                    end
                    OP_JMP: jump = 1'b1;
                    OP_JC:  jump = c_flag;
                    OP_JZ:  jump = z_flag;
                    OP_OUT: out_en = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // datapath registers; a taken jump overrides the fetch increment
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            out_q  <= '0;
            out_v  <= 1'b0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            out_v <= out_en;
            if (do_fetch) begin
                ir <= fetch_word[IR_W-1:0];
                pc <= pc + 1'b1;
            end
            if (jump) pc <= opd;
            if (ld_a) begin
                acc    <= a_nxt;
                z_flag <= arith ? alu_z : (a_nxt == '0);
            end
            if (arith)  c_flag <= alu_c;
            if (out_en) out_q  <= acc;
        end
    end

    // program RAM: host writes when quiescent, STA writes in EXEC
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (prog_ok && PROG_WE) mem[PROG_ADDR] <= PROG_DATA;
            else if (sta_we)        mem[opd]       <= acc;
        end
    end

    assign PC_OUT    = pc;
    assign A_OUT     = acc;
    assign OUT_DATA  = out_q;
    assign OUT_VALID = out_v;
    assign CARRY     = c_flag;
    assign ZERO      = z_flag;
    assign HALTED    = (state == S_HALT);

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: directed vectors and sequences for sap_core,
// plus a wide-address instance exercising 12/8-bit parameters.
module tb_sap_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic       PROG_WE = 1'b0;
    logic [3:0] PROG_ADDR = '0;
    logic [7:0] PROG_DATA = '0;
    logic [3:0] PC_OUT;
    logic [7:0] A_OUT;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       CARRY;
    logic       ZERO;
    logic       HALTED;

    logic        rst2 = 1'b1;
    logic        run2 = 1'b0;
    logic        step2 = 1'b0;
    logic        we2 = 1'b0;
    logic [7:0]  addr2 = '0;
    logic [11:0] data2 = '0;
    logic [7:0]  pc2;
    logic [11:0] a2;
    logic [11:0] od2;
    logic        ov2;
    logic        c2;
    logic        z2;
    logic        h2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 CLK = ~CLK;

    sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP),
        .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .PC_OUT(PC_OUT), .A_OUT(A_OUT), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .CARRY(CARRY), .ZERO(ZERO), .HALTED(HALTED)
    );

    sap_core #(.DATA_W(12), .ADDR_W(8)) dut2 (
        .CLK(CLK), .RST(rst2), .RUN(run2), .STEP(step2),
        .PROG_WE(we2), .PROG_ADDR(addr2), .PROG_DATA(data2),
        .PC_OUT(pc2), .A_OUT(a2), .OUT_DATA(od2),
        .OUT_VALID(ov2), .CARRY(c2), .ZERO(z2), .HALTED(h2)
    );

    typedef struct {
        logic [3:0] opc;
        logic [7:0] a_init;
        logic [7:0] m_val;
        logic [7:0] exp_a;
        logic       exp_c;
        logic       exp_z;
        logic [3:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic load(input logic [3:0] ad, input logic [7:0] d);
        PROG_ADDR = ad;
        PROG_DATA = d;
        PROG_WE   = 1'b1;
        tick();
        PROG_WE   = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int max_cyc);
        int n;
        n = 0;
        RUN = 1'b1;
        while (!HALTED && n < max_cyc) begin
            tick();
            n++;
        end
        RUN = 1'b0;
        check({name, "_halt"}, HALTED, 1);
    endtask

    task automatic do_step();
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int pulses;
        int p_at;
        int h_at;
        int p1;
        int p2;
        logic [11:0] od_first;

        vecs[0]  = '{4'h2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 4'h3};
        vecs[1]  = '{4'h2, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 4'h3};
        vecs[2]  = '{4'h2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 4'h3};
        vecs[3]  = '{4'h3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 4'h3};
        vecs[4]  = '{4'h3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 4'h3};
        vecs[5]  = '{4'h3, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 4'h3};
        vecs[6]  = '{4'h1, 8'h33, 8'h00, 8'h00, 1'b0, 1'b1, 4'h3};
        vecs[7]  = '{4'h5, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0, 4'h3};
        vecs[8]  = '{4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 4'h3};
        vecs[9]  = '{4'h9, 8'h44, 8'h00, 8'h44, 1'b0, 1'b0, 4'h3};
        vecs[10] = '{4'h7, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b1, 4'h3};
        vecs[11] = '{4'h8, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b1, 4'h0};
        vecs[12] = '{4'h4, 8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 4'h3};

        #2;
        check("reset_state",
              {PC_OUT, A_OUT, OUT_DATA, OUT_VALID, CARRY, ZERO, HALTED}, 0);
        tick();
        RST = 1'b0;

        // single-instruction vectors: LDA E ; <op> F ; HLT
        for (int i = 0; i < 13; i++) begin
            do_reset();
            load(4'hE, vecs[i].a_init);
            load(4'hF, vecs[i].m_val);
            load(4'h0, 8'h1E);
            load(4'h1, {vecs[i].opc, 4'hF});
            load(4'h2, 8'hF0);
            run_to_halt($sformatf("vec%0d", i), 40);
            check($sformatf("vec%0d_acz", i), {A_OUT, CARRY, ZERO},
                  {vecs[i].exp_a, vecs[i].exp_c, vecs[i].exp_z});
            check($sformatf("vec%0d_pc", i), PC_OUT, vecs[i].exp_pc);
        end

        // LDA 9, ADD A, OUT, HLT
        do_reset();
        load(4'h0, 8'h19);
        load(4'h1, 8'h2A);
        load(4'h2, 8'hE0);
        load(4'h3, 8'hF0);
        load(4'h9, 8'h1C);
        load(4'hA, 8'h0E);
        pulses = 0;
        p_at = 0;
        RUN = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (OUT_VALID) begin
                pulses++;
                p_at = i;
            end
        end
        RUN = 1'b0;
        check("sum_out_data", OUT_DATA, 8'h2A);
        check("sum_pulses", pulses, 1);
        check("sum_pulse_edge", p_at, 7);
        check("sum_halted", HALTED, 1);
        check("sum_pc", PC_OUT, 4);

        // countdown: LDI 3, SUB E, JZ 4, JMP 1, OUT, HLT ; M[E]=1
        do_reset();
        load(4'h0, 8'h53);
        load(4'h1, 8'h3E);
        load(4'h2, 8'h84);
        load(4'h3, 8'h61);
        load(4'h4, 8'hE0);
        load(4'h5, 8'hF0);
        load(4'hE, 8'h01);
        pulses = 0;
        p_at = 0;
        h_at = 0;
        RUN = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (OUT_VALID) begin
                pulses++;
                p_at = i;
            end
            if (HALTED && h_at == 0) h_at = i;
        end
        RUN = 1'b0;
        check("cd_out_data", OUT_DATA, 0);
        check("cd_pulses", pulses, 1);
        check("cd_pulse_edge", p_at, 21);
        check("cd_halt_edge", h_at, 23);

        // stepping, with a host write attempted during EXEC
        do_reset();
        load(4'h0, 8'h51);
        load(4'h1, 8'h52);
        load(4'h2, 8'h53);
        load(4'h3, 8'hF0);
        do_step();
        check("step1", {PC_OUT, A_OUT}, {4'h1, 8'h01});
        tick();
        tick();
        check("step1_idle", {PC_OUT, HALTED}, {4'h1, 1'b0});
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        tick();
        PROG_ADDR = 4'h2;
        PROG_DATA = 8'h59;
        PROG_WE   = 1'b1;
        tick();
        PROG_WE   = 1'b0;
        check("step2", {PC_OUT, A_OUT}, {4'h2, 8'h02});
        do_step();
        check("step3_exec_we_ignored", {PC_OUT, A_OUT}, {4'h3, 8'h03});
        load(4'h3, 8'h57);
        do_step();
        check("step4_idle_we", {PC_OUT, A_OUT, HALTED}, {4'h4, 8'h07, 1'b0});

        // JMP F then NOP at F wraps PC to 0
        do_reset();
        load(4'h0, 8'h6F);
        load(4'hF, 8'h00);
        do_step();
        check("jmp_pc", PC_OUT, 4'hF);
        do_step();
        check("wrap_pc", PC_OUT, 4'h0);

        // host write and RUN in the same idle cycle
        do_reset();
        load(4'h0, 8'hF0);
        load(4'h1, 8'hF0);
        PROG_ADDR = 4'h0;
        PROG_DATA = 8'h56;
        PROG_WE   = 1'b1;
        RUN       = 1'b1;
        tick();
        PROG_WE   = 1'b0;
        run_to_halt("we_run", 20);
        check("we_run_state", {PC_OUT, A_OUT}, {4'h2, 8'h06});

        // async reset in EXEC of STA discards the write
        do_reset();
        load(4'h0, 8'h55);
        load(4'h1, 8'h4D);
        load(4'h2, 8'hF0);
        load(4'hD, 8'h77);
        RUN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        RUN = 1'b0;
        check("pre_rst_pc", PC_OUT, 4'h2);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst",
              {PC_OUT, A_OUT, OUT_DATA, OUT_VALID, CARRY, ZERO, HALTED}, 0);
        tick();
        RST = 1'b0;
        load(4'h0, 8'h1D);
        load(4'h1, 8'hF0);
        run_to_halt("sta_abort", 20);
        check("sta_abort_mem", A_OUT, 8'h77);

        // 12-bit data / 8-bit address instance, full 256-word wrap
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            addr2 = 8'(i);
            data2 = (i == 0) ? 12'h5FF : ((i == 1) ? 12'hE00 : 12'h000);
            we2   = 1'b1;
            tick();
        end
        we2 = 1'b0;
        p1 = 0;
        p2 = 0;
        od_first = '0;
        run2 = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (ov2) begin
                if (p1 == 0) begin
                    p1 = i;
                    od_first = od2;
                end else if (p2 == 0) begin
                    p2 = i;
                end
            end
        end
        run2 = 1'b0;
        check("w_out_data", od_first, 12'h0FF);
        check("w_first_edge", p1, 5);
        check("w_wrap_period", p2 - p1, 512);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
